// File: rtl/countdown_timer_pkg.sv
// -----------------------------------------------------------------------------
// countdown_timer_pkg
// Shared definitions for the countdown timer: FSM state encoding, field widths
// (identical to the calendar clock so the two blocks can share buses) and the
// default per-field maximum values.
// -----------------------------------------------------------------------------
package countdown_timer_pkg;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;
    localparam int DAY_W = 5;

    localparam int SEC_MAX_DEF = 59;
    localparam int MIN_MAX_DEF = 59;
    localparam int HR_MAX_DEF  = 23;
    localparam int DAY_MAX_DEF = 29;   // 30-day month

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/countdown_timer_borrow_digit.sv
// -----------------------------------------------------------------------------
// countdown_timer_borrow_digit
// One field of the countdown (seconds, minutes, hours or days). Loads a clamped
// value, decrements on request and reloads MAX when decremented from zero (the
// borrow into the next field is formed by the caller from zero_o).
//
// Ports:
//   clk, reset     clock, async active-high reset (value -> 0)
//   load_i         load clamp_o into the field at the next edge
//   load_val_i     raw value to load
//   dec_i          decrement by one at the next edge (borrow when zero)
//   value_o        current field value
//   clamp_o        load_val_i limited to MAX
//   zero_o         field currently holds zero
// -----------------------------------------------------------------------------
module countdown_timer_borrow_digit #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] value_o,
    output logic [W-1:0] clamp_o,
    output logic         zero_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    assign clamp_o = (load_val_i > MAX_V) ? MAX_V : load_val_i;
    assign zero_o  = (value_q == '0);
    assign value_o = value_q;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = clamp_o;
        end else if (dec_i) begin
            value_d = zero_o ? MAX_V : (value_q - 1'b1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
// Days:hours:minutes:seconds down-counter driven by the shared one-second tick.
// Stops at zero, pulses expired for one cycle on reaching zero.
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   tick                            one-second strobe (one clk wide)
//   load, load_sec/min/hr/day       load request and duration fields
//   start, pause                    run control
//   seconds/minutes/hours/days      remaining count
//   running                         registered, high while in RUN
//   expired                         one-cycle pulse when count reaches zero
//
// state     | meaning
// ----------+----------------------------------------------
// ST_IDLE   | loaded or reset, waiting for start
// ST_RUN    | counting down on tick
// ST_PAUSED | count held, start resumes
// ST_DONE   | reached zero, holds until a new load
// -----------------------------------------------------------------------------
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int SEC_MAX = SEC_MAX_DEF,
    parameter int MIN_MAX = MIN_MAX_DEF,
    parameter int HR_MAX  = HR_MAX_DEF,
    parameter int DAY_MAX = DAY_MAX_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic [SEC_W-1:0] load_sec,
    input  logic [MIN_W-1:0] load_min,
    input  logic [HR_W-1:0]  load_hr,
    input  logic [DAY_W-1:0] load_day,
    input  logic             start,
    input  logic             pause,
    output logic [SEC_W-1:0] seconds,
    output logic [MIN_W-1:0] minutes,
    output logic [HR_W-1:0]  hours,
    output logic [DAY_W-1:0] days,
    output logic             running,
    output logic             expired
);

    state_e state_q, state_d;
    logic   running_q, running_d;
    logic   expired_q, expired_d;

    logic load_acc;
    logic step;
    logic last_step;
    logic sec_dec, min_dec, hr_dec, day_dec;
    logic sec_zero, min_zero, hr_zero, day_zero;
    logic count_zero, clamp_zero, eff_zero;

    logic [SEC_W-1:0] sec_clamp;
    logic [MIN_W-1:0] min_clamp;
    logic [HR_W-1:0]  hr_clamp;
    logic [DAY_W-1:0] day_clamp;

    // A load is only honoured outside RUN; it then also defines the count
    // that start has to see as nonzero in the same cycle.
    assign load_acc   = load && (state_q != ST_RUN);
    assign count_zero = sec_zero && min_zero && hr_zero && day_zero;
    assign clamp_zero = (sec_clamp == '0) && (min_clamp == '0) &&
                        (hr_clamp == '0) && (day_clamp == '0);
    assign eff_zero   = load_acc ? clamp_zero : count_zero;

    assign sec_dec = step;
    assign min_dec = sec_dec && sec_zero;
    assign hr_dec  = min_dec && min_zero;
    assign day_dec = hr_dec && hr_zero;

    assign last_step = step && (seconds == SEC_W'(1)) &&
                       min_zero && hr_zero && day_zero;

    countdown_timer_borrow_digit #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
        .clk(clk), .reset(reset), .load_i(load_acc), .load_val_i(load_sec),
        .dec_i(sec_dec), .value_o(seconds), .clamp_o(sec_clamp), .zero_o(sec_zero)
    );

    countdown_timer_borrow_digit #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
        .clk(clk), .reset(reset), .load_i(load_acc), .load_val_i(load_min),
        .dec_i(min_dec), .value_o(minutes), .clamp_o(min_clamp), .zero_o(min_zero)
    );

    countdown_timer_borrow_digit #(.W(HR_W), .MAX(HR_MAX)) u_hr (
        .clk(clk), .reset(reset), .load_i(load_acc), .load_val_i(load_hr),
        .dec_i(hr_dec), .value_o(hours), .clamp_o(hr_clamp), .zero_o(hr_zero)
    );

    countdown_timer_borrow_digit #(.W(DAY_W), .MAX(DAY_MAX)) u_day (
        .clk(clk), .reset(reset), .load_i(load_acc), .load_val_i(load_day),
        .dec_i(day_dec), .value_o(days), .clamp_o(day_clamp), .zero_o(day_zero)
    );

    always_comb begin
        state_d = state_q;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !eff_zero) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // pause beats both start and a coincident tick
                if (pause) begin
                    state_d = ST_PAUSED;
                end else if (tick && !count_zero) begin
                    step = 1'b1;
                    if (last_step) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_PAUSED: begin
                if (start && !eff_zero) begin
                    state_d = ST_RUN;
                end else if (load) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (load) begin
                    state_d = (start && !eff_zero) ? ST_RUN : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign running_d = (state_d == ST_RUN);
    assign expired_d = last_step;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            expired_q <= expired_d;
        end
    end

    assign running = running_q;
    assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
// Directed stimulus for countdown_timer; expected outputs are queued when a
// cycle's inputs are driven and popped after the following clock edge.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick, load, start, pause;
    logic [5:0] load_sec, load_min;
    logic [4:0] load_hr, load_day;
    logic [5:0] seconds, minutes;
    logic [4:0] hours, days;
    logic       running, expired;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        string      tag;
        logic [5:0] s;
        logic [5:0] m;
        logic [4:0] h;
        logic [4:0] d;
        logic       r;
        logic       e;
    } exp_t;

    exp_t sb[$];

    countdown_timer dut (
        .clk(clk), .reset(reset), .tick(tick), .load(load),
        .load_sec(load_sec), .load_min(load_min), .load_hr(load_hr), .load_day(load_day),
        .start(start), .pause(pause),
        .seconds(seconds), .minutes(minutes), .hours(hours), .days(days),
        .running(running), .expired(expired)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_all(input exp_t x);
        chk({x.tag, ".sec"}, int'(seconds), int'(x.s));
        chk({x.tag, ".min"}, int'(minutes), int'(x.m));
        chk({x.tag, ".hr"},  int'(hours),   int'(x.h));
        chk({x.tag, ".day"}, int'(days),    int'(x.d));
        chk({x.tag, ".running"}, int'(running), int'(x.r));
        chk({x.tag, ".expired"}, int'(expired), int'(x.e));
    endtask

    // One clock cycle: drive inputs at negedge, queue the expectation, pop and
    // compare just after the following posedge.
    task automatic cyc(input string tag,
                       input logic t, input logic l, input logic st, input logic ps,
                       input int ls, input int lm, input int lh, input int ldy,
                       input int es, input int em, input int eh, input int ed,
                       input logic er, input logic ee);
        exp_t x;
        @(negedge clk);
        tick = t; load = l; start = st; pause = ps;
        load_sec = 6'(ls); load_min = 6'(lm); load_hr = 5'(lh); load_day = 5'(ldy);
        x.tag = tag; x.s = 6'(es); x.m = 6'(em); x.h = 5'(eh); x.d = 5'(ed);
        x.r = er; x.e = ee;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk_all(x);
        tick = 0; load = 0; start = 0; pause = 0;
    endtask

    task automatic chk_zero_now(input string tag);
        exp_t x;
        x.tag = tag; x.s = 0; x.m = 0; x.h = 0; x.d = 0; x.r = 0; x.e = 0;
        chk_all(x);
    endtask

    initial begin
        reset = 1'b1;
        tick = 0; load = 0; start = 0; pause = 0;
        load_sec = 0; load_min = 0; load_hr = 0; load_day = 0;
        #12;
        chk_zero_now("reset");
        @(negedge clk);
        reset = 1'b0;

        // 3-second countdown to expiry
        //   tag            t  l  st ps  ls lm lh ld   es em eh ed  r  e
        cyc("ld3",         0, 1, 0, 0,  3, 0, 0, 0,   3, 0, 0, 0,  0, 0);
        cyc("start3",      0, 0, 1, 0,  0, 0, 0, 0,   3, 0, 0, 0,  1, 0);
        cyc("t3a",         1, 0, 0, 0,  0, 0, 0, 0,   2, 0, 0, 0,  1, 0);
        cyc("t3b",         1, 0, 0, 0,  0, 0, 0, 0,   1, 0, 0, 0,  1, 0);
        cyc("t3c_expire",  1, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 1);
        cyc("done_hold",   0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0);
        cyc("done_tick",   1, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0);
        cyc("done_start",  0, 0, 1, 0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0);

        // one minute: minutes -> seconds borrow, then full run to expiry
        cyc("ld1m_start",  0, 1, 1, 0,  0, 1, 0, 0,   0, 1, 0, 0,  1, 0);
        cyc("1m_borrow",   1, 0, 0, 0,  0, 0, 0, 0,  59, 0, 0, 0,  1, 0);
        for (int i = 1; i <= 58; i++) begin
            cyc("1m_run",  1, 0, 0, 0,  0, 0, 0, 0,  59 - i, 0, 0, 0, 1, 0);
        end
        cyc("1m_expire",   1, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 1);

        // one day: full borrow chain
        cyc("ld1d_start",  0, 1, 1, 0,  0, 0, 0, 1,   0, 0, 0, 1,  1, 0);
        cyc("1d_chain",    1, 0, 0, 0,  0, 0, 0, 0,  59, 59, 23, 0, 1, 0);
        cyc("1d_pause",    0, 0, 0, 1,  0, 0, 0, 0,  59, 59, 23, 0, 0, 0);

        // pause / resume behaviour at 10 s
        cyc("ld10",        0, 1, 0, 0, 10, 0, 0, 0,  10, 0, 0, 0,  0, 0);
        cyc("start10",     0, 0, 1, 0,  0, 0, 0, 0,  10, 0, 0, 0,  1, 0);
        cyc("pause_tick",  1, 0, 0, 1,  0, 0, 0, 0,  10, 0, 0, 0,  0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc("paused_tick", 1, 0, 0, 0, 0, 0, 0, 0, 10, 0, 0, 0, 0, 0);
        end
        cyc("resume_sp",   0, 0, 1, 1,  0, 0, 0, 0,  10, 0, 0, 0,  1, 0);
        cyc("res_t1",      1, 0, 0, 0,  0, 0, 0, 0,   9, 0, 0, 0,  1, 0);
        cyc("res_t2",      1, 0, 0, 0,  0, 0, 0, 0,   8, 0, 0, 0,  1, 0);
        cyc("run_load_ign",1, 1, 0, 0,  5, 0, 0, 0,   7, 0, 0, 0,  1, 0);
        cyc("run_ps_win",  0, 0, 1, 1,  0, 0, 0, 0,   7, 0, 0, 0,  0, 0);

        // clamping and zero-count start
        cyc("ld_clamp",    0, 1, 0, 0, 62, 63, 31, 31, 59, 59, 23, 29, 0, 0);
        cyc("ld_zero",     0, 1, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0);
        cyc("start_zero",  0, 0, 1, 0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0);
        cyc("ldz_start",   0, 1, 1, 0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0);

        // asynchronous reset mid-count
        cyc("ld5_start",   0, 1, 1, 0,  5, 0, 0, 0,   5, 0, 0, 0,  1, 0);
        cyc("t5",          1, 0, 0, 0,  0, 0, 0, 0,   4, 0, 0, 0,  1, 0);
        #2 reset = 1'b1;
        #1 chk_zero_now("async_rst");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc("post_rst_tick", 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0);
        cyc("post_rst_start",0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0);

        // reset cancels a pending expired pulse
        cyc("ld1_start",   0, 1, 1, 0,  1, 0, 0, 0,   1, 0, 0, 0,  1, 0);
        cyc("t1_expire",   1, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 1);
        #2 reset = 1'b1;
        #1 chk_zero_now("rst_cancel_exp");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc("idle_after",  0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0);

        chk("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
